// File: rtl/i2c_target.sv
// i2c_target: 7-bit-address I2C target with a byte-wide write (rx) and read (tx) handshake.
// SCL/SDA are oversampled on clk; all bus timing is derived from synchronized edges.
module i2c_target #(
   parameter logic [6:0] SLAVE_ADDR = 7'h42
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       sda_oe,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_req,
   output logic       busy
);
   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] ADDR     = 3'd1;
   localparam logic [2:0] ADDR_ACK = 3'd2;
   localparam logic [2:0] WR_BYTE  = 3'd3;
   localparam logic [2:0] WR_ACK   = 3'd4;
   localparam logic [2:0] RD_BYTE  = 3'd5;
   localparam logic [2:0] RD_MACK  = 3'd6;
   localparam logic [2:0] IGNORE   = 3'd7;

   logic [2:0] scl_s, sda_s, state, cnt;
   logic [7:0] sr;
   logic       full;
   logic       scl_rise, scl_fall, start, stop, sda;

   assign scl_rise = scl_s[1] & ~scl_s[2];
   assign scl_fall = ~scl_s[1] & scl_s[2];
   assign start    = scl_s[1] & sda_s[2] & ~sda_s[1];
   assign stop     = scl_s[1] & ~sda_s[2] & sda_s[1];
   assign sda      = sda_s[1];
   assign busy     = state != IDLE;

   // full marks that all 8 bits of a received byte have been shifted in
   always_ff @(posedge clk) begin
      if (rst) begin
         scl_s    <= '1;
         sda_s    <= '1;
         state    <= IDLE;
         cnt      <= '0;
         sr       <= '0;
         full     <= 1'b0;
         sda_oe   <= 1'b0;
         rx_data  <= '0;
         rx_valid <= 1'b0;
         tx_req   <= 1'b0;
      end else begin
         scl_s    <= {scl_s[1:0], scl_in};
         sda_s    <= {sda_s[1:0], sda_in};
         rx_valid <= 1'b0;
         tx_req   <= 1'b0;
         if (start) begin
            state  <= ADDR;
            sda_oe <= 1'b0;
            cnt    <= '0;
            full   <= 1'b0;
         end else if (stop) begin
            state  <= IDLE;
            sda_oe <= 1'b0;
            full   <= 1'b0;
         end else begin
            case (state)
               ADDR, WR_BYTE: begin
                  if (scl_rise) begin
                     sr   <= {sr[6:0], sda};
                     cnt  <= cnt + 3'd1;
                     full <= cnt == 3'd7;
                  end else if (scl_fall && full) begin
                     full <= 1'b0;
                     if (state == WR_BYTE) begin
                        rx_data  <= sr;
                        rx_valid <= 1'b1;
                        sda_oe   <= 1'b1;
                        state    <= WR_ACK;
                     end else if (sr[7:1] == SLAVE_ADDR) begin
                        sda_oe <= 1'b1;
                        state  <= ADDR_ACK;
                     end else begin
                        state <= IGNORE;
                     end
                  end
               end
               // both end on an SCL fall that either starts a read byte or a write byte
               ADDR_ACK, RD_MACK: begin
                  if (state == RD_MACK && scl_rise && sda) begin
                     state <= IGNORE;
                  end else if (scl_fall && (state == RD_MACK || sr[0])) begin
                     tx_req <= 1'b1;
                     sr     <= tx_data;
                     sda_oe <= ~tx_data[7];
                     cnt    <= '0;
                     state  <= RD_BYTE;
                  end else if (scl_fall) begin
                     sda_oe <= 1'b0;
                     cnt    <= '0;
                     state  <= WR_BYTE;
                  end
               end
               WR_ACK: begin
                  if (scl_fall) begin
                     sda_oe <= 1'b0;
                     state  <= WR_BYTE;
                  end
               end
               RD_BYTE: begin
                  if (scl_fall) begin
                     if (cnt == 3'd7) begin
                        sda_oe <= 1'b0;
                        state  <= RD_MACK;
                     end else begin
                        sr     <= {sr[6:0], 1'b0};
                        sda_oe <= ~sr[6];
                        cnt    <= cnt + 3'd1;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: bit-banged I2C master driving i2c_target, checked against a
// transaction-level model (expected ACKs, expected byte queue, request counts).
module tb_i2c_target;
   localparam int Q = 5;
   localparam logic [6:0] ADR = 7'h42;
   typedef logic [7:0] bq_t[$];

   logic clk = 1'b0, rst = 1'b1, scl = 1'b1, sda_m = 1'b1, ovr = 1'b0;
   logic sda_oe, rx_valid, tx_req, busy, sda_line;
   logic [7:0] rx_data, tx_data = 8'h00;
   int n_chk = 0, n_pass = 0, rx_cnt = 0, tx_cnt = 0;
   logic [7:0] exp_q[$];
   logic quiet = 1'b1;

   // wired-AND bus; ovr lets the master override the target to force a STOP
   assign sda_line = ovr ? sda_m : (sda_m & ~sda_oe);

   i2c_target #(.SLAVE_ADDR(ADR)) dut (
      .clk(clk), .rst(rst), .scl_in(scl), .sda_in(sda_line), .sda_oe(sda_oe),
      .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_req(tx_req), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (rx_valid || tx_req) chk("rx_tx_exclusive", 32'(rx_valid & tx_req), 0);
         if (rx_valid) begin
            rx_cnt++;
            chk("rx_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) chk("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
         end
         if (tx_req) tx_cnt++;
         if (quiet) chk("sda_quiet", 32'(sda_oe), 0);
      end
   end

   task automatic hold(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic start_c;
      sda_m = 1'b1; hold(Q); scl = 1'b1; hold(Q); sda_m = 1'b0; hold(Q); scl = 1'b0; hold(Q);
   endtask

   task automatic stop_c;
      sda_m = 1'b0; hold(Q); scl = 1'b1; hold(Q); sda_m = 1'b1; hold(Q);
   endtask

   task automatic bit_c(input logic b, output logic r);
      sda_m = b; hold(Q); scl = 1'b1; hold(Q); r = sda_line; hold(Q); scl = 1'b0; hold(Q);
   endtask

   task automatic wr_byte(input logic [7:0] d, output logic ack);
      logic r;
      for (int i = 7; i >= 0; i--) bit_c(d[i], r);
      bit_c(1'b1, r);
      ack = ~r;
   endtask

   task automatic rd_byte(input logic mack, output logic [7:0] d);
      logic r;
      for (int i = 7; i >= 0; i--) begin
         bit_c(1'b1, r);
         d[i] = r;
      end
      bit_c(~mack, r);
   endtask

   task automatic xfer_write(input logic [6:0] a, input bq_t dq);
      logic ack, hit;
      hit = (a == ADR);
      quiet = ~hit;
      rx_cnt = 0;
      start_c;
      wr_byte({a, 1'b0}, ack);
      chk("wr_addr_ack", 32'(ack), 32'(hit));
      chk("busy_in_xfer", 32'(busy), 1);
      foreach (dq[i]) begin
         if (hit) exp_q.push_back(dq[i]);
         wr_byte(dq[i], ack);
         chk("wr_data_ack", 32'(ack), 32'(hit));
      end
      stop_c;
      chk("busy_after_stop", 32'(busy), 0);
      chk("rx_count", rx_cnt, hit ? dq.size() : 0);
      chk("rx_queue_drained", exp_q.size(), 0);
      quiet = 1'b1;
   endtask

   task automatic xfer_read(input logic [6:0] a, input bq_t dq, output logic [7:0] last);
      logic ack, hit;
      logic [7:0] d;
      hit = (a == ADR);
      quiet = ~hit;
      tx_cnt = 0;
      tx_data = dq[0];
      start_c;
      wr_byte({a, 1'b1}, ack);
      chk("rd_addr_ack", 32'(ack), 32'(hit));
      for (int i = 0; i < dq.size(); i++) begin
         if (i + 1 < dq.size()) tx_data = dq[i+1];
         rd_byte(i + 1 < dq.size(), d);
         chk("rd_data", 32'(d), hit ? 32'(dq[i]) : 32'hFF);
      end
      last = d;
      chk("sda_free_after_nack", 32'(sda_oe), 0);
      quiet = 1'b1;
      stop_c;
      chk("busy_after_stop", 32'(busy), 0);
      chk("tx_count", tx_cnt, hit ? dq.size() : 0);
   endtask

   initial begin
      logic ack, r;
      logic [7:0] last;
      bq_t q;
      hold(3);
      chk("rst_sda_oe", 32'(sda_oe), 0);
      chk("rst_rx_valid", 32'(rx_valid), 0);
      chk("rst_tx_req", 32'(tx_req), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_rx_data", 32'(rx_data), 0);
      rst = 1'b0;
      hold(Q);
      // basic write
      q = {8'hA5};
      xfer_write(7'h42, q);
      chk("wr_lit_rx_data", 32'(rx_data), 32'hA5);
      // read two bytes, ACK then NACK
      q = {8'h3C, 8'hC3};
      xfer_read(7'h42, q, last);
      chk("rd_lit_last", 32'(last), 32'hC3);
      chk("rd_lit_tx_count", tx_cnt, 2);
      // wrong address is ignored until STOP
      q = {8'h11};
      xfer_write(7'h23, q);
      chk("ign_lit_rx_data", 32'(rx_data), 32'hA5);
      // repeated START in the middle of a data byte
      quiet = 1'b0;
      rx_cnt = 0;
      start_c;
      wr_byte(8'h84, ack);
      chk("rs_addr_ack", 32'(ack), 1);
      for (int i = 0; i < 4; i++) bit_c(1'($urandom), r);
      q = {8'h96, 8'h0F};
      xfer_read(7'h42, q, last);
      chk("rs_no_partial_rx", rx_cnt, 0);
      chk("rs_lit_tx_count", tx_cnt, 2);
      // reset while the target pulls SDA low on a read bit
      quiet = 1'b0;
      tx_data = 8'h3C;
      start_c;
      wr_byte(8'h85, ack);
      chk("rr_addr_ack", 32'(ack), 1);
      chk("rr_driving_low", 32'(sda_oe), 1);
      rst = 1'b1;
      hold(1);
      chk("rr_sda_released", 32'(sda_oe), 0);
      chk("rr_busy", 32'(busy), 0);
      chk("rr_rx_data", 32'(rx_data), 0);
      rst = 1'b0;
      quiet = 1'b1;
      q = {8'h5A};
      xfer_write(7'h42, q);
      chk("rr_lit_rx_data", 32'(rx_data), 32'h5A);
      // STOP during the target's data ACK
      quiet = 1'b0;
      rx_cnt = 0;
      start_c;
      wr_byte(8'h84, ack);
      exp_q.push_back(8'h77);
      for (int i = 7; i >= 0; i--) bit_c(1'(8'h77 >> i), r);
      sda_m = 1'b1; hold(Q); scl = 1'b1; hold(Q);
      chk("sa_ack_low", 32'(sda_line), 0);
      ovr = 1'b1;
      hold(4);
      chk("sa_sda_released", 32'(sda_oe), 0);
      chk("sa_busy", 32'(busy), 0);
      chk("sa_rx_count", rx_cnt, 1);
      ovr = 1'b0;
      quiet = 1'b1;
      hold(Q);
      // randomized traffic
      for (int k = 0; k < 16; k++) begin
         logic [6:0] a;
         int n;
         a = ($urandom_range(0, 2) != 0) ? ADR : 7'($urandom);
         n = $urandom_range(1, 3);
         q = {};
         for (int j = 0; j < n; j++) q.push_back(8'($urandom));
         if ($urandom_range(0, 1) != 0) xfer_write(a, q);
         else xfer_read(a, q, last);
      end
      hold(Q);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
